// File: rtl/accel_counter_unit.sv
// rtl/accel_counter_unit.sv - low/high programmable wrap-around cycle counters with compare-match ready
// Two identical, independent counter channels sharing one clock and asynchronous reset.

module accel_counter_ch #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] period,
    input  logic [W-1:0] interrupt,
    output logic         ready,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } cnt_state_t;

    cnt_state_t   state_q, state_d;
    logic [W-1:0] per_q, int_q;
    logic [W-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         ready_q;
    logic         err_q;
    logic         reconfig;

    always_comb begin
        reconfig = (period != per_q) || (interrupt != int_q);
        count_d  = count_q;
        wrap_d   = 1'b0;
        state_d  = state_q;

        // Any change of period or compare value restarts from zero and drops en for that cycle.
        if (reconfig) begin
            count_d = '0;
            state_d = IDLE;
        end else begin
            if (en) begin
                if (count_q == period) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            case (state_q)
                IDLE:    if (en)  state_d = RUN;
                RUN:     if (!en) state_d = HOLD;
                HOLD:    if (en)  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // ready is computed from the next count so it lines up with the count it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            int_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= period;
            int_q   <= interrupt;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ready_q <= (count_d == interrupt);
            err_q   <= err_q | (interrupt > period);
        end
    end

    assign ready   = ready_q;
    assign count   = count_q;
    assign wrap    = wrap_q;
    assign cfg_err = err_q;

endmodule

module accel_counter_unit #(
    parameter int WIDTH_LBIT_CNT = 5,
    parameter int WIDTH_HBIT_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      LCNT_en_i,
    input  logic [WIDTH_LBIT_CNT-1:0] LCNT_period_i,
    input  logic [WIDTH_LBIT_CNT-1:0] LCNT_interrupt_i,
    output logic                      LCNT_ready_o,
    output logic [WIDTH_LBIT_CNT-1:0] LCNT_count_o,
    output logic                      LCNT_wrap_o,
    input  logic                      HCNT_en_i,
    input  logic [WIDTH_HBIT_CNT-1:0] HCNT_period_i,
    input  logic [WIDTH_HBIT_CNT-1:0] HCNT_interrupt_i,
    output logic                      HCNT_ready_o,
    output logic [WIDTH_HBIT_CNT-1:0] HCNT_count_o,
    output logic                      HCNT_wrap_o,
    output logic [1:0]                cfg_err_o
);

    logic l_err, h_err;

    accel_counter_ch #(.W(WIDTH_LBIT_CNT)) u_lcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (LCNT_en_i),
        .period    (LCNT_period_i),
        .interrupt (LCNT_interrupt_i),
        .ready     (LCNT_ready_o),
        .count     (LCNT_count_o),
        .wrap      (LCNT_wrap_o),
        .cfg_err   (l_err)
    );

    accel_counter_ch #(.W(WIDTH_HBIT_CNT)) u_hcnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (HCNT_en_i),
        .period    (HCNT_period_i),
        .interrupt (HCNT_interrupt_i),
        .ready     (HCNT_ready_o),
        .count     (HCNT_count_o),
        .wrap      (HCNT_wrap_o),
        .cfg_err   (h_err)
    );

    assign cfg_err_o = {h_err, l_err};

endmodule

// File: tb/tb_accel_counter_unit.sv
// tb/tb_accel_counter_unit.sv - scoreboard bench for accel_counter_unit
// Stimulus pushes expected values tagged with a cycle (or -1 for async reset); a monitor pops and compares.

module tb_accel_counter_unit;

    localparam int S_LC = 0, S_LR = 1, S_LW = 2, S_HC = 3, S_HR = 4, S_HW = 5, S_ERR = 6, S_LST = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       l_en = 1'b0, h_en = 1'b0;
    logic [4:0] l_per = 5'd0, l_int = 5'd0;
    logic [2:0] h_per = 3'd0, h_int = 3'd0;
    logic       l_ready, l_wrap, h_ready, h_wrap;
    logic [4:0] l_count;
    logic [2:0] h_count;
    logic [1:0] cfg_err;

    typedef struct {
        int key;
        int sel;
        int exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    accel_counter_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .LCNT_en_i        (l_en),
        .LCNT_period_i    (l_per),
        .LCNT_interrupt_i (l_int),
        .LCNT_ready_o     (l_ready),
        .LCNT_count_o     (l_count),
        .LCNT_wrap_o      (l_wrap),
        .HCNT_en_i        (h_en),
        .HCNT_period_i    (h_per),
        .HCNT_interrupt_i (h_int),
        .HCNT_ready_o     (h_ready),
        .HCNT_count_o     (h_count),
        .HCNT_wrap_o      (h_wrap),
        .cfg_err_o        (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sname(input int sel);
        case (sel)
            S_LC:    return "lcnt_count";
            S_LR:    return "lcnt_ready";
            S_LW:    return "lcnt_wrap";
            S_HC:    return "hcnt_count";
            S_HR:    return "hcnt_ready";
            S_HW:    return "hcnt_wrap";
            S_ERR:   return "cfg_err";
            default: return "lcnt_state";
        endcase
    endfunction

    function automatic int actual(input int sel);
        case (sel)
            S_LC:    return int'(l_count);
            S_LR:    return int'(l_ready);
            S_LW:    return int'(l_wrap);
            S_HC:    return int'(h_count);
            S_HR:    return int'(h_ready);
            S_HW:    return int'(h_wrap);
            S_ERR:   return int'(cfg_err);
            default: return int'(dut.u_lcnt.state_q);
        endcase
    endfunction

    task automatic chk(input int sel, input int val);
        sb.push_back('{cyc, sel, val});
    endtask

    task automatic chk_rst(input int sel, input int val);
        sb.push_back('{-1, sel, val});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: clock wakes (clk low) consume entries for this cycle; reset wakes (clk high) consume key -1.
    initial begin
        exp_t e;
        bit   rst_wake;
        int   a;
        forever begin
            @(negedge clk or negedge rst_n);
            rst_wake = (clk == 1'b1);
            #1;
            while (sb.size() > 0 && ((rst_wake && sb[0].key == -1) ||
                   (!rst_wake && (sb[0].key == -1 || sb[0].key <= cyc)))) begin
                e = sb.pop_front();
                tests++;
                a = actual(e.sel);
                if (!rst_wake && e.key != cyc) begin
                    fails++;
                    $display("FAIL %s: expectation for cycle %0d not checked in time (now cycle %0d)",
                             sname(e.sel), e.key, cyc);
                end else if (a != e.exp) begin
                    fails++;
                    $display("FAIL %s @cycle %0d: got %0d, expected %0d", sname(e.sel), e.key, a, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state, idle inputs all zero
        tick();
        chk(S_LC, 0); chk(S_LR, 1); chk(S_LW, 0); chk(S_HC, 0); chk(S_HR, 1); chk(S_HW, 0); chk(S_ERR, 0);

        // T2: period=16, int=16
        l_per = 5'd16; l_int = 5'd16;
        tick();
        chk(S_LC, 0); chk(S_LR, 0); chk(S_LST, 0);
        l_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk(S_LC, i); chk(S_LR, (i == 16) ? 1 : 0); chk(S_LW, 0);
        end

        // T3: hold at match value
        l_en = 1'b0;
        repeat (3) begin
            tick();
            chk(S_LC, 16); chk(S_LR, 1); chk(S_LW, 0); chk(S_LST, 2);
        end
        l_en = 1'b1;
        tick();
        chk(S_LC, 0); chk(S_LW, 1); chk(S_LR, 0); chk(S_LST, 1);
        tick();
        chk(S_LC, 1); chk(S_LW, 0);

        // Reconfig while count==period: clear without wrap
        l_per = 5'd3; l_int = 5'd3;
        tick();
        chk(S_LC, 0); chk(S_LST, 0);
        repeat (3) tick();
        chk(S_LC, 3); chk(S_LR, 1);
        l_int = 5'd0;
        tick();
        chk(S_LC, 0); chk(S_LW, 0); chk(S_LR, 1); chk(S_LST, 0);

        // T4: period 31/int 2, then reconfigure to 16/16 at count 5
        l_per = 5'd31; l_int = 5'd2;
        tick();
        chk(S_LC, 0); chk(S_LR, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk(S_LC, i); chk(S_LR, (i == 2) ? 1 : 0);
        end
        l_per = 5'd16; l_int = 5'd16;
        tick();
        chk(S_LC, 0); chk(S_LW, 0); chk(S_LST, 0); chk(S_LR, 0);
        tick();
        chk(S_LC, 1); chk(S_LST, 1);

        // T5: H period=7, int=7, en pulsed one cycle in four
        l_en = 1'b0;
        h_per = 3'd7; h_int = 3'd7;
        tick();
        chk(S_HC, 0); chk(S_HR, 0);
        for (int p = 1; p <= 8; p++) begin
            h_en = 1'b1;
            tick();
            chk(S_HC, p % 8); chk(S_HR, (p == 7) ? 1 : 0); chk(S_HW, (p == 8) ? 1 : 0);
            h_en = 1'b0;
            repeat (3) tick();
            chk(S_HC, p % 8); chk(S_HR, (p == 7) ? 1 : 0); chk(S_HW, 0);
        end
        chk(S_LC, 1);

        // T6: interrupt > period
        l_per = 5'd3; l_int = 5'd5;
        tick();
        chk(S_ERR, 1); chk(S_LR, 0); chk(S_LC, 0);
        l_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk(S_LR, 0); chk(S_LC, k % 4); chk(S_LW, (k % 4 == 0) ? 1 : 0);
        end
        chk(S_ERR, 1);
        l_per = 5'd0; l_int = 5'd0;
        tick();
        chk(S_LC, 0); chk(S_LR, 1); chk(S_LW, 0); chk(S_ERR, 1);
        repeat (5) begin
            tick();
            chk(S_LW, 1); chk(S_LC, 0); chk(S_LR, 1);
        end
        h_per = 3'd2; h_int = 3'd6;
        tick();
        chk(S_ERR, 3); chk(S_HR, 0);

        // T1: asynchronous reset mid-count
        l_per = 5'd31; l_int = 5'd31;
        h_en = 1'b1; h_per = 3'd7; h_int = 3'd7;
        tick();
        chk(S_LC, 0);
        for (int i = 1; i <= 8; i++) tick();
        chk(S_LC, 8); chk(S_HC, 0);
        tick();
        rst_n = 1'b0;
        chk_rst(S_LC, 0); chk_rst(S_LW, 0); chk_rst(S_LR, 1);
        chk_rst(S_HC, 0); chk_rst(S_HR, 1); chk_rst(S_ERR, 0);
        tick();
        chk(S_LC, 0); chk(S_HC, 0); chk(S_LR, 1);
        rst_n = 1'b1;
        // First edge after release acts as a reconfiguration
        tick();
        chk(S_LC, 0); chk(S_LR, 0); chk(S_LW, 0);
        tick();
        chk(S_LC, 1); chk(S_HC, 1);

        repeat (3) tick();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
